vec_switch: RTL and testbench

- Central inter-core data switch.
- Each vector core's send port acts as initiator into this block; each core's receive port is serviced by this block as responder.
- Each source core owns a one-entry mailbox holding one SWITCH_WIDTH-element shortreal vector tagged with its destination.
- A destination core drains the mailbox by requesting that source index.

---
 rtl/vec_switch_pkg.sv | 22 ++
 rtl/vec_switch_mailbox.sv | 69 ++++++
 rtl/vec_switch.sv | 75 +++++++
 tb/tb_vec_switch.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_switch_pkg.sv
// Shared types and sizing for the inter-core vector switch.
package vec_switch_pkg;

    localparam int unsigned SWITCH_WIDTH          = 16;
    localparam int unsigned SWITCH_CORE_SIZE      = 4;
    localparam int unsigned SWITCH_CORE_ADDR_SIZE = $clog2(SWITCH_CORE_SIZE);

    typedef logic [SWITCH_CORE_ADDR_SIZE-1:0] VecSwitchIdx_t;

    typedef enum logic {
        MBOX_EMPTY,
        MBOX_FULL
    } VecSwitchMboxState_t;

    // One source mailbox: occupancy, destination tag and payload.
    typedef struct {
        logic          valid;
        VecSwitchIdx_t dest;
        shortreal      data [SWITCH_WIDTH];
    } VecSwitchMbox_t;

endpackage

// File: rtl/vec_switch_mailbox.sv
// One-entry mailbox owned by a single source core. Accepts a vector only when
// empty at the start of the cycle and releases it only when full, so a fill and
// a drain can never happen in the same cycle.
module vec_switch_mailbox
    import vec_switch_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          send_ready,
    input  VecSwitchIdx_t send_core_idx,
    input  shortreal      send_data [SWITCH_WIDTH],
    input  logic          drain,
    output logic          send_ok,
    output logic          full,
    output VecSwitchIdx_t dest,
    output shortreal      data [SWITCH_WIDTH]
);

    VecSwitchMboxState_t state_q, state_d;
    VecSwitchMbox_t      mbox_q;
    logic                accept;

    // Next-state decode: fill from EMPTY, drain from FULL.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            MBOX_EMPTY: begin
                if (send_ready) begin
                    accept  = 1'b1;
                    state_d = MBOX_FULL;
                end
            end
            MBOX_FULL: begin
                if (drain) begin
                    state_d = MBOX_EMPTY;
                end
            end
        endcase
    end

    // State, payload latch and the registered one-cycle accept pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= MBOX_EMPTY;
            send_ok      <= 1'b0;
            mbox_q.valid <= 1'b0;
            mbox_q.dest  <= '0;
            for (int i = 0; i < SWITCH_WIDTH; i++) begin
                mbox_q.data[i] <= 0.0;
            end
        end else begin
            state_q      <= state_d;
            send_ok      <= accept;
            mbox_q.valid <= (state_d == MBOX_FULL);
            if (accept) begin
                mbox_q.dest <= send_core_idx;
                for (int i = 0; i < SWITCH_WIDTH; i++) begin
                    mbox_q.data[i] <= send_data[i];
                end
            end
        end
    end

    assign full = mbox_q.valid;
    assign dest = mbox_q.dest;
    assign data = mbox_q.data;

endmodule

// File: rtl/vec_switch.sv
// Central inter-core data switch: one mailbox per source core, drained by the
// destination core it is tagged for. Delivery is registered, so recv_ready is a
// one-cycle pulse and recv_data holds the last delivered vector.
module vec_switch
    import vec_switch_pkg::*;
(
    input  logic                                                clock,
    input  logic                                                reset,
    input  logic [SWITCH_CORE_SIZE-1:0]                         send_ready,
    input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_CORE_ADDR_SIZE-1:0] send_core_idx,
    input  shortreal                                            send_data [SWITCH_CORE_SIZE][SWITCH_WIDTH],
    output logic [SWITCH_CORE_SIZE-1:0]                         send_ok,
    input  logic [SWITCH_CORE_SIZE-1:0]                         recv_request,
    input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_CORE_ADDR_SIZE-1:0] recv_core_idx,
    output logic [SWITCH_CORE_SIZE-1:0]                         recv_ready,
    output shortreal                                            recv_data [SWITCH_CORE_SIZE][SWITCH_WIDTH],
    output logic [SWITCH_CORE_SIZE-1:0]                         mbox_full
);

    logic [SWITCH_CORE_SIZE-1:0] drain;
    logic [SWITCH_CORE_SIZE-1:0] hit;
    VecSwitchIdx_t               mbox_dest [SWITCH_CORE_SIZE];
    shortreal                    mbox_data [SWITCH_CORE_SIZE][SWITCH_WIDTH];

    for (genvar g = 0; g < SWITCH_CORE_SIZE; g++) begin : g_mbox
        vec_switch_mailbox u_mbox (
            .clock         (clock),
            .reset         (reset),
            .send_ready    (send_ready[g]),
            .send_core_idx (send_core_idx[g]),
            .send_data     (send_data[g]),
            .drain         (drain[g]),
            .send_ok       (send_ok[g]),
            .full          (mbox_full[g]),
            .dest          (mbox_dest[g]),
            .data          (mbox_data[g])
        );
    end

    // Destination d hits when the source it names is full and tagged for d.
    // Only the tagged destination can match, so at most one hit drains a source.
    always_comb begin
        hit   = '0;
        drain = '0;
        for (int d = 0; d < SWITCH_CORE_SIZE; d++) begin
            if (recv_request[d] && mbox_full[recv_core_idx[d]] &&
                (mbox_dest[recv_core_idx[d]] == VecSwitchIdx_t'(d))) begin
                hit[d]                = 1'b1;
                drain[recv_core_idx[d]] = 1'b1;
            end
        end
    end

    // Registered delivery: pulse recv_ready and capture the drained vector.
    always_ff @(posedge clock) begin
        if (reset) begin
            recv_ready <= '0;
            for (int d = 0; d < SWITCH_CORE_SIZE; d++) begin
                for (int e = 0; e < SWITCH_WIDTH; e++) begin
                    recv_data[d][e] <= 0.0;
                end
            end
        end else begin
            recv_ready <= hit;
            for (int d = 0; d < SWITCH_CORE_SIZE; d++) begin
                if (hit[d]) begin
                    for (int e = 0; e < SWITCH_WIDTH; e++) begin
                        recv_data[d][e] <= mbox_data[recv_core_idx[d]][e];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vec_switch.sv
// Self-checking bench for vec_switch: directed scenarios plus a randomized run,
// all checked against a cycle-level mailbox model kept here.
module tb_vec_switch;
    import vec_switch_pkg::*;

    localparam int N = SWITCH_CORE_SIZE;
    localparam int W = SWITCH_WIDTH;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [N-1:0]          send_ready;
    logic [N-1:0][SWITCH_CORE_ADDR_SIZE-1:0] send_core_idx;
    shortreal              send_data [N][W];
    logic [N-1:0]          send_ok;
    logic [N-1:0]          recv_request;
    logic [N-1:0][SWITCH_CORE_ADDR_SIZE-1:0] recv_core_idx;
    logic [N-1:0]          recv_ready;
    shortreal              recv_data [N][W];
    logic [N-1:0]          mbox_full;

    int errors = 0;
    int checks = 0;

    // Reference model state and expected outputs.
    logic [N-1:0]  m_full;
    VecSwitchIdx_t m_dest [N];
    shortreal      m_data [N][W];
    logic [N-1:0]  e_ok;
    logic [N-1:0]  e_rdy;
    shortreal      e_rdata [N][W];

    always #5 clock = ~clock;

    vec_switch dut (
        .clock         (clock),
        .reset         (reset),
        .send_ready    (send_ready),
        .send_core_idx (send_core_idx),
        .send_data     (send_data),
        .send_ok       (send_ok),
        .recv_request  (recv_request),
        .recv_core_idx (recv_core_idx),
        .recv_ready    (recv_ready),
        .recv_data     (recv_data),
        .mbox_full     (mbox_full)
    );

    // Advance the model by one cycle from the current inputs, then the clock.
    task automatic tick();
        logic [N-1:0] drn;
        int s;
        if (reset) begin
            m_full = '0;
            e_ok   = '0;
            e_rdy  = '0;
            for (int d = 0; d < N; d++) begin
                m_dest[d] = '0;
                for (int e = 0; e < W; e++) e_rdata[d][e] = 0.0;
            end
        end else begin
            drn   = '0;
            e_ok  = '0;
            e_rdy = '0;
            for (int d = 0; d < N; d++) begin
                s = int'(recv_core_idx[d]);
                if (recv_request[d] && m_full[s] && int'(m_dest[s]) == d) begin
                    e_rdy[d] = 1'b1;
                    drn[s]   = 1'b1;
                    for (int e = 0; e < W; e++) e_rdata[d][e] = m_data[s][e];
                end
            end
            for (int c = 0; c < N; c++) begin
                if (send_ready[c] && !m_full[c]) begin
                    e_ok[c]   = 1'b1;
                    m_full[c] = 1'b1;
                    m_dest[c] = send_core_idx[c];
                    for (int e = 0; e < W; e++) m_data[c][e] = send_data[c][e];
                end else if (drn[c]) begin
                    m_full[c] = 1'b0;
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic load(input int c, input shortreal base);
        for (int e = 0; e < W; e++) send_data[c][e] = base + shortreal'(e);
    endtask

    task automatic idle_inputs();
        send_ready   = '0;
        recv_request = '0;
    endtask

    task automatic test_reset();
        int bad;
        idle_inputs();
        send_core_idx = '0;
        recv_core_idx = '0;
        for (int c = 0; c < N; c++) load(c, 0.0);
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (5) tick();
        checks++;
        if (send_ok !== '0 || recv_ready !== '0 || mbox_full !== '0) begin
            errors++;
            $display("FAIL reset_flags: send_ok=%b recv_ready=%b mbox_full=%b required all 0",
                     send_ok, recv_ready, mbox_full);
        end
        bad = 0;
        for (int d = 0; d < N; d++)
            for (int e = 0; e < W; e++) if (recv_data[d][e] != 0.0) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_data: %0d nonzero elements, required 0", bad);
        end
    endtask

    task automatic test_basic();
        int bad;
        load(0, 1.0);
        send_core_idx[0] = 2'd2;
        send_ready[0]    = 1'b1;
        recv_core_idx[2] = 2'd0;
        recv_request[2]  = 1'b1;
        tick();
        checks++;
        if (send_ok !== 4'b0001 || mbox_full !== 4'b0001 || recv_ready !== 4'b0000) begin
            errors++;
            $display("FAIL basic_t1: send_ok=%b mbox_full=%b recv_ready=%b required 0001 0001 0000",
                     send_ok, mbox_full, recv_ready);
        end
        tick();
        checks++;
        if (recv_ready !== 4'b0100 || mbox_full !== 4'b0000 || send_ok !== 4'b0000) begin
            errors++;
            $display("FAIL basic_t2: recv_ready=%b mbox_full=%b send_ok=%b required 0100 0000 0000",
                     recv_ready, mbox_full, send_ok);
        end
        bad = 0;
        for (int e = 0; e < W; e++) if (recv_data[2][e] != shortreal'(e + 1)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL basic_data: %0d elements differ, elem0=%f required 1.0", bad,
                     recv_data[2][0]);
        end
        idle_inputs();
        tick();
        checks++;
        if (send_ok !== '0 || recv_ready !== '0 || recv_data[2][15] != 16.0) begin
            errors++;
            $display("FAIL basic_t3: send_ok=%b recv_ready=%b elem15=%f required 0 0 16.0",
                     send_ok, recv_ready, recv_data[2][15]);
        end
    endtask

    task automatic test_stall();
        int bad;
        load(1, 100.0);
        send_core_idx[1] = 2'd3;
        send_ready[1]    = 1'b1;
        recv_core_idx[2] = 2'd1;
        recv_request[2]  = 1'b1;
        tick();
        checks++;
        if (send_ok !== 4'b0010) begin
            errors++;
            $display("FAIL stall_accept: send_ok=%b required 0010", send_ok);
        end
        send_ready[1] = 1'b0;
        bad = 0;
        repeat (20) begin
            tick();
            if (recv_ready[2] !== 1'b0 || mbox_full[1] !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_hold: %0d cycles with a wrong-destination drain, required 0", bad);
        end
        recv_request[2]  = 1'b0;
        recv_core_idx[3] = 2'd1;
        recv_request[3]  = 1'b1;
        tick();
        checks++;
        if (recv_ready !== 4'b1000 || mbox_full[1] !== 1'b0 || recv_data[3][4] != 104.0) begin
            errors++;
            $display("FAIL stall_release: recv_ready=%b full1=%b elem4=%f required 1000 0 104.0",
                     recv_ready, mbox_full[1], recv_data[3][4]);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        int ok_cyc [$];
        int rx_cyc [$];
        shortreal got [$];
        int bad;
        bit sent_b;
        sent_b = 1'b0;
        bad    = 0;
        load(0, 200.0);
        send_core_idx[0] = 2'd1;
        send_ready[0]    = 1'b1;
        recv_core_idx[1] = 2'd0;
        recv_request[1]  = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            tick();
            if (send_ok !== e_ok || recv_ready !== e_rdy) bad++;
            if (recv_ready[1]) begin
                rx_cyc.push_back(cyc);
                got.push_back(recv_data[1][0]);
                for (int e = 0; e < W; e++)
                    if (recv_data[1][e] != recv_data[1][0] + shortreal'(e)) bad++;
            end
            if (send_ok[0]) begin
                ok_cyc.push_back(cyc);
                if (!sent_b) begin
                    load(0, 300.0);
                    sent_b = 1'b1;
                end else begin
                    send_ready[0] = 1'b0;
                end
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL b2b_model: %0d cycle/vector mismatches, required 0", bad);
        end
        checks++;
        if (ok_cyc.size() != 2 || ok_cyc[0] != 1 || ok_cyc[1] != 3) begin
            errors++;
            $display("FAIL b2b_send_ok: %0d pulses (first %0d), required pulses at cycles 1 and 3",
                     ok_cyc.size(), (ok_cyc.size() > 0) ? ok_cyc[0] : -1);
        end
        checks++;
        if (got.size() != 2 || got[0] != 200.0 || got[1] != 300.0 ||
            rx_cyc[0] != 2 || rx_cyc[1] != 4) begin
            errors++;
            $display("FAIL b2b_order: received %0d vectors, required A(200.0)@2 then B(300.0)@4",
                     got.size());
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_parallel();
        // Permutation of destinations that includes the self-send 2->2.
        int dst [N] = '{1, 3, 2, 0};
        int bad;
        for (int c = 0; c < N; c++) begin
            load(c, shortreal'(1000 * (c + 1)));
            send_core_idx[c]      = VecSwitchIdx_t'(dst[c]);
            send_ready[c]         = 1'b1;
            recv_core_idx[dst[c]] = VecSwitchIdx_t'(c);
            recv_request[dst[c]]  = 1'b1;
        end
        tick();
        checks++;
        if (send_ok !== 4'b1111 || mbox_full !== 4'b1111 || recv_ready !== 4'b0000) begin
            errors++;
            $display("FAIL par_accept: send_ok=%b mbox_full=%b recv_ready=%b required 1111 1111 0000",
                     send_ok, mbox_full, recv_ready);
        end
        tick();
        checks++;
        if (recv_ready !== 4'b1111 || mbox_full !== 4'b0000) begin
            errors++;
            $display("FAIL par_deliver: recv_ready=%b mbox_full=%b required 1111 0000",
                     recv_ready, mbox_full);
        end
        bad = 0;
        for (int c = 0; c < N; c++)
            for (int e = 0; e < W; e++)
                if (recv_data[dst[c]][e] != shortreal'(1000 * (c + 1) + e)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL par_routing: %0d misrouted elements, required 0", bad);
        end
        idle_inputs();
        tick();
        checks++;
        if (send_ok !== '0 || recv_ready !== '0) begin
            errors++;
            $display("FAIL par_no_double: send_ok=%b recv_ready=%b required 0000 0000",
                     send_ok, recv_ready);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        load(3, 500.0);
        send_core_idx[3] = 2'd0;
        send_ready[3]    = 1'b1;
        tick();
        send_ready[3] = 1'b0;
        checks++;
        if (mbox_full !== 4'b1000) begin
            errors++;
            $display("FAIL rst_fill: mbox_full=%b required 1000", mbox_full);
        end
        reset            = 1'b1;
        recv_core_idx[0] = 2'd3;
        recv_request[0]  = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (recv_ready !== '0 || mbox_full !== '0 || send_ok !== '0) begin
            errors++;
            $display("FAIL rst_clear: recv_ready=%b mbox_full=%b send_ok=%b required all 0",
                     recv_ready, mbox_full, send_ok);
        end
        bad = 0;
        repeat (6) begin
            tick();
            if (recv_ready[0] !== 1'b0 || recv_data[0][0] == 500.0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rst_no_delivery: old vector seen in %0d cycles, required 0", bad);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        int age [N];
        int bad;
        for (int d = 0; d < N; d++) age[d] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int c = 0; c < N; c++) begin
                if (!send_ready[c] && $urandom_range(2, 0) == 0) begin
                    send_ready[c]    = 1'b1;
                    send_core_idx[c] = VecSwitchIdx_t'($urandom_range(N - 1, 0));
                    for (int e = 0; e < W; e++)
                        send_data[c][e] = shortreal'($urandom_range(9999, 0)) / 8.0;
                end
            end
            for (int d = 0; d < N; d++) begin
                if (!recv_request[d] && $urandom_range(1, 0) == 0) begin
                    recv_request[d]  = 1'b1;
                    recv_core_idx[d] = VecSwitchIdx_t'($urandom_range(N - 1, 0));
                    age[d]           = 0;
                end else if (recv_request[d] && age[d] > 8) begin
                    // Retarget a long-stalled request so the run cannot deadlock.
                    recv_core_idx[d] = VecSwitchIdx_t'($urandom_range(N - 1, 0));
                    age[d]           = 0;
                end
            end
            tick();
            checks++;
            if (send_ok !== e_ok) begin
                errors++;
                $display("FAIL rnd_send_ok cyc %0d: got %b required %b", cyc, send_ok, e_ok);
            end
            checks++;
            if (recv_ready !== e_rdy) begin
                errors++;
                $display("FAIL rnd_recv_ready cyc %0d: got %b required %b", cyc, recv_ready, e_rdy);
            end
            checks++;
            if (mbox_full !== m_full) begin
                errors++;
                $display("FAIL rnd_mbox_full cyc %0d: got %b required %b", cyc, mbox_full, m_full);
            end
            bad = 0;
            for (int d = 0; d < N; d++)
                for (int e = 0; e < W; e++) if (recv_data[d][e] != e_rdata[d][e]) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL rnd_recv_data cyc %0d: %0d elements differ, required 0", cyc, bad);
            end
            for (int c = 0; c < N; c++) if (send_ok[c]) send_ready[c] = 1'b0;
            for (int d = 0; d < N; d++) begin
                if (recv_ready[d]) recv_request[d] = 1'b0;
                else age[d]++;
            end
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_parallel();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
